// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: one SRAM-like bus request per PC value, a one-entry
// buffer across IF/ID stalls, and cancellation of fetches invalidated by a flush.
module if_fetch_ctrl #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   input  logic          rom_enable,
   input  logic          flush,
   input  logic          id_stall,
   output logic          inst_req,
   output logic [AW-1:0] inst_addr,
   input  logic          inst_addr_ok,
   input  logic          inst_data_ok,
   input  logic [DW-1:0] inst_rdata,
   output logic [DW-1:0] inst,
   output logic          inst_valid,
   output logic          stallreq_if
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t        state;
   state_t        state_next;
   logic          cancel;
   logic          cancel_next;
   logic [DW-1:0] buffer;
   logic          buffer_load;
   logic          discard;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cancel <= 1'b0;
         buffer <= '0;
      end else begin
         state  <= state_next;
         cancel <= cancel_next;
         if (buffer_load) begin
            buffer <= inst_rdata;
         end
      end
   end

   always_comb begin
      state_next  = state;
      cancel_next = 1'b0;
      buffer_load = 1'b0;
      inst_req    = 1'b0;
      inst_valid  = 1'b0;
      inst        = '0;
      // Returned data is stale if the fetch was flushed earlier, is flushed now,
      // or the PC side has dropped rom_enable.
      discard     = cancel | flush | ~rom_enable;
      case (state)
         IDLE: begin
            if (rom_enable && !flush) begin
               state_next = REQ;
            end
         end
         REQ: begin
            inst_req = rom_enable;
            if (!rom_enable) begin
               state_next = IDLE;
            end else if (inst_addr_ok) begin
               state_next  = WAIT;
               cancel_next = flush;
            end else if (flush) begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (!inst_data_ok) begin
               cancel_next = discard;
            end else if (discard) begin
               state_next = rom_enable ? REQ : IDLE;
            end else if (id_stall) begin
               buffer_load = 1'b1;
               state_next  = HOLD;
            end else begin
               inst_valid = 1'b1;
               inst       = inst_rdata;
               state_next = REQ;
            end
         end
         HOLD: begin
            if (!rom_enable) begin
               state_next = IDLE;
            end else if (flush) begin
               state_next = REQ;
            end else if (!id_stall) begin
               inst_valid = 1'b1;
               inst       = buffer;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign inst_addr   = pc;
   assign stallreq_if = rom_enable & ~inst_valid & ~flush;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Random-stimulus bench for if_fetch_ctrl: models the PC register and the bus,
// and checks every delivered instruction against the program-order scoreboard.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        rom_enable;
   logic        flush;
   logic        id_stall;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        stallreq_if;

   int          checks = 0;
   int          errors = 0;
   int          deliveries = 0;

   // expected instruction for each PC value in program order
   logic [31:0] sb_q[$];
   logic [31:0] mon_exp;

   bit          pend;
   logic [31:0] pend_addr;
   int          pend_dly;
   bit          drove_real;
   bit          do_adv;
   bit          do_flush;
   logic [31:0] exc_pc;
   bit          prev_req;
   bit          prev_ok;
   logic [31:0] prev_addr;
   int          n;

   always #5 clk = ~clk;

   if_fetch_ctrl #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .rom_enable   (rom_enable),
      .flush        (flush),
      .id_stall     (id_stall),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .inst         (inst),
      .inst_valid   (inst_valid),
      .stallreq_if  (stallreq_if)
   );

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h2401_0001;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // One cycle of environment: PC register, bus slave, random control inputs.
   task automatic step(input bit fast, input bit rst_n, input bit rom);
      @(negedge clk);
      reset      = rst_n;
      rom_enable = rom;
      if (do_flush) begin
         if (sb_q.size() > 0) void'(sb_q.pop_front());
         pc = exc_pc;
         sb_q.push_back(mem(pc));
      end else if (do_adv) begin
         pc = pc + 32'd4;
         sb_q.push_back(mem(pc));
      end
      if (!rst_n) begin
         pc = 32'hbfc00000;
         sb_q.delete();
         sb_q.push_back(mem(pc));
         pend = 1'b0;
      end
      flush        = !fast && rom && ($urandom_range(0, 19) == 0);
      id_stall     = !fast && ($urandom_range(0, 3) == 0);
      inst_addr_ok = fast || ($urandom_range(0, 1) == 1);
      drove_real   = rst_n && pend && (pend_dly == 0);
      if (drove_real) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem(pend_addr);
      end else if (!rom || (!fast && !pend && $urandom_range(0, 9) == 0)) begin
         inst_data_ok = 1'b1;
         inst_rdata   = 32'hdeadbeef;
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = $urandom;
      end
      #3;
      if (drove_real) pend = 1'b0;
      else if (pend && pend_dly > 0) pend_dly--;
      if (inst_req && inst_addr_ok) begin
         pend      = 1'b1;
         pend_addr = inst_addr;
         pend_dly  = fast ? 0 : int'($urandom_range(0, 3));
      end
      do_flush = rst_n && flush;
      do_adv   = rst_n && rom_enable && !flush && !stallreq_if;
      exc_pc   = 32'hbfc00380 + ($urandom_range(0, 1023) << 2);
   endtask

   task automatic check_reset_outputs();
      check("rst_inst_req", inst_req, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_stallreq", stallreq_if, 0);
   endtask

   always @(negedge clk) begin
      #2;
      if (inst_valid) begin
         check("valid_during_flush", flush, 0);
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery actual=%h expected=none t=%0t", inst, $time);
         end else begin
            mon_exp = sb_q.pop_front();
            check("inst_data", inst, mon_exp);
            deliveries++;
         end
      end else begin
         check("inst_zero_when_idle", inst, 0);
      end
      check("stallreq", stallreq_if, rom_enable & ~inst_valid & ~flush);
      if (inst_req) begin
         check("inst_addr_pc", inst_addr, pc);
         check("one_outstanding", pend, 0);
         if (prev_req && !prev_ok) check("addr_hold", inst_addr, prev_addr);
      end
      prev_req  = inst_req;
      prev_ok   = inst_addr_ok;
      prev_addr = inst_addr;
   end

   initial begin
      reset        = 1'b0;
      rom_enable   = 1'b0;
      flush        = 1'b0;
      id_stall     = 1'b0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      pc           = 32'hbfc00000;
      pend         = 1'b0;
      pend_addr    = '0;
      pend_dly     = 0;
      drove_real   = 1'b0;
      do_adv       = 1'b0;
      do_flush     = 1'b0;
      exc_pc       = '0;
      prev_req     = 1'b0;
      prev_ok      = 1'b0;
      prev_addr    = '0;

      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_reset_outputs();
      step(1'b0, 1'b1, 1'b0);
      check("release_no_req", inst_req, 0);

      // zero-wait bus: request and delivery alternate from the cycle after rom_enable rises
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 1'b1);
         if (k == 0) begin
            check("first_idle_req", inst_req, 0);
            check("first_stall", stallreq_if, 1);
         end else if (k % 2 == 1) begin
            check("fast_req", inst_req, 1);
            check("fast_addr", inst_addr, 32'hbfc00000 + 32'(4 * ((k - 1) / 2)));
            check("fast_no_valid", inst_valid, 0);
            check("fast_req_stall", stallreq_if, 1);
         end else begin
            check("fast_valid", inst_valid, 1);
            check("fast_deliver_req", inst_req, 0);
            check("fast_deliver_stall", stallreq_if, 0);
         end
      end

      for (int i = 0; i < 2000; i++) step(1'b0, 1'b1, 1'b1);

      // reset while a request is outstanding, with late data_ok around it
      n = 0;
      while (!pend && n < 100) begin
         step(1'b0, 1'b1, 1'b1);
         n++;
      end
      check("reach_wait", pend, 1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check_reset_outputs();
      step(1'b0, 1'b1, 1'b0);
      check("late_data_ignored", inst_valid, 0);
      step(1'b0, 1'b1, 1'b1);
      check("restart_idle_req", inst_req, 0);

      for (int i = 0; i < 500; i++) step(1'b0, 1'b1, 1'b1);

      check("progress", deliveries > 150, 1);
      @(negedge clk);
      #4;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
